// File: rtl/serial_lane_tx.sv
// serial_lane_tx
// ----------------------------------------------------------------------------
// Parallel-to-serial transmit stage for one routed lane. Words are popped from
// the routing output FIFO and shifted out MSB-first as a continuous bit stream.
// When the FIFO has nothing ready, a comma/idle word fills the slot, so the
// link never starves. A sync comma is always sent first after enable rises.
//
// Optional feature (compile-time macro SERIAL_LANE_PARITY_EN):
//   defined     -> each word is followed by an even-parity bit (FRAME = DATA_SIZE+1)
//   not defined -> FRAME = DATA_SIZE, no parity bit
//
// Ports:
//   clk         single clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   enable      lane transmit enable
//   in          word from routing FIFO, valid the cycle after pop
//   fifo_empty  routing FIFO empty flag
//   pop         one-cycle read strobe to the routing FIFO
//   data_out    serial bit
//   k_out       high while bits of an idle/comma word are on data_out
//   word_start  high during the first bit of every word
//   active      high while in SHIFT (exposes the FSM state)
//   data_cnt    count of data (non-idle) words loaded; wraps silently
//
// FIFO handshake: pop is a request strobe issued only when fifo_empty=0; the
// FIFO answers with a fixed 1-cycle latency (pop high before edge T, in is
// sampled at edge T+1). There is no back-pressure: a popped word is always
// transmitted unless reset intervenes.
// ----------------------------------------------------------------------------
module serial_lane_tx #(
  parameter int                   DATA_SIZE = 8,
  parameter logic [DATA_SIZE-1:0] IDLE_WORD = 8'hBC,
  parameter int                   CNT_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_SIZE-1:0] in,
  input  logic                 fifo_empty,
  output logic                 pop,
  output logic                 data_out,
  output logic                 k_out,
  output logic                 word_start,
  output logic                 active,
  output logic [CNT_SIZE-1:0]  data_cnt
);

`ifdef SERIAL_LANE_PARITY_EN
  localparam int FRAME = DATA_SIZE + 1;
`else
  localparam int FRAME = DATA_SIZE;
`endif
  localparam int BW = $clog2(FRAME);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
  localparam logic [BW-1:0] POP_BIT  = BW'(FRAME - 2);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_n;
  logic [FRAME-1:0]      shreg_q, shreg_n;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_n;
  logic                  k_q, k_n;
  logic                  pop_q;
  logic [CNT_SIZE-1:0]   cnt_q, cnt_n;

  // Serial frame of one word: the word itself, plus the even-parity bit
  // appended after the LSB when parity is enabled.
  function automatic logic [FRAME-1:0] make_frame(input logic [DATA_SIZE-1:0] w);
`ifdef SERIAL_LANE_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      k_q       <= 1'b0;
      pop_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_n;
      shreg_q   <= shreg_n;
      bit_cnt_q <= bit_cnt_n;
      k_q       <= k_n;
      pop_q     <= pop;
      cnt_q     <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    shreg_n    = shreg_q;
    bit_cnt_n  = bit_cnt_q;
    k_n        = k_q;
    cnt_n      = cnt_q;
    pop        = 1'b0;
    data_out   = 1'b0;
    k_out      = 1'b0;
    word_start = 1'b0;
    active     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          // Link start always begins with a sync comma.
          shreg_n   = make_frame(IDLE_WORD);
          k_n       = 1'b1;
          bit_cnt_n = '0;
          state_n   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        active     = 1'b1;
        data_out   = shreg_q[FRAME-1];
        k_out      = k_q;
        word_start = (bit_cnt_q == '0);
        // Request the next word one cycle ahead so it arrives exactly at the
        // last bit of the current word and the stream stays gapless.
        pop        = (bit_cnt_q == POP_BIT) && enable && !fifo_empty;

        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_n = '0;
          if (pop_q) begin
            // A popped word is sent even if enable has dropped meanwhile.
            shreg_n = make_frame(in);
            k_n     = 1'b0;
            cnt_n   = cnt_q + CNT_SIZE'(1);
          end else if (enable) begin
            shreg_n = make_frame(IDLE_WORD);
            k_n     = 1'b1;
          end else begin
            shreg_n = '0;
            k_n     = 1'b0;
            state_n = ST_IDLE;
          end
        end else begin
          shreg_n   = {shreg_q[FRAME-2:0], 1'b0};
          bit_cnt_n = bit_cnt_q + BW'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign data_cnt = cnt_q;

endmodule

// File: tb/tb_serial_lane_tx.sv
// Testbench for serial_lane_tx. A queue-based FIFO model answers pops with a
// 1-cycle latency; the expected bit stream is built from the sequence of words
// that should appear on the link (sync/idle commas and data words, each laid
// out MSB-first with an optional even-parity bit counted by $countones).
module tb_serial_lane_tx;
`ifdef SERIAL_LANE_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif
  localparam int CW = 4;              // small counter so wrap is reachable
  localparam logic [7:0] IDLE = 8'hBC;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    in;
  logic          fifo_empty;
  logic          pop, data_out, k_out, word_start, active;
  logic [CW-1:0] data_cnt;

  int checks = 0;
  int fails  = 0;

  logic [7:0] fifo_q[$];
  logic [4:0] exp_q[$];   // {active, data_out, k_out, word_start, pop}
  logic [4:0] obs_q[$];

  serial_lane_tx #(.DATA_SIZE(8), .IDLE_WORD(8'hBC), .CNT_SIZE(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in(in),
    .fifo_empty(fifo_empty), .pop(pop), .data_out(data_out), .k_out(k_out),
    .word_start(word_start), .active(active), .data_cnt(data_cnt)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  initial begin : fifo_model
    logic pop_s;
    in = 8'h00;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      pop_s = pop;
      @(posedge clk);
      #1;
      if (pop_s && fifo_q.size() > 0) in = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- driver / model tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    obs_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Expected samples for one transmitted word; pop_next marks that the next
  // word on the link is a data word, so pop must fire one bit before the end.
  task automatic add_word(input logic [7:0] w, input logic k, input logic pop_next);
    logic [8:0] f;
    f = {w, 1'b0};
    if (FRAME == 9) f[0] = ($countones(w) % 2) == 1;
    for (int b = 0; b < FRAME; b++)
      exp_q.push_back({1'b1, f[8-b], k, (b == 0), (pop_next && b == FRAME - 2)});
  endtask

  task automatic add_quiet(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(5'b0);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_q.push_back({active, data_out, k_out, word_start, pop});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    #3;
    checks++;
    if ({pop, data_out, k_out, word_start, active, data_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_values: got %b required all zero",
               {pop, data_out, k_out, word_start, active, data_cnt});
    end
    do_reset();
  endtask

  task automatic test_idle_fill();
    do_reset();
    enable = 1'b1;
    add_quiet(1);
    for (int i = 0; i < 4; i++) add_word(IDLE, 1'b1, 1'b0);
    capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL idle_fill cycle %0d: got %b required %b (act,dout,k,ws,pop)", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (data_cnt !== '0) begin
      fails++;
      $display("FAIL idle_fill_cnt: got %0d required 0", data_cnt);
    end
  endtask

  task automatic test_data_stream();
    do_reset();
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    add_quiet(1);
    add_word(IDLE, 1'b1, 1'b1);
    add_word(8'hA5, 1'b0, 1'b1);
    add_word(8'h3C, 1'b0, 1'b0);
    add_word(IDLE, 1'b1, 1'b0);
    add_word(IDLE, 1'b1, 1'b0);
    capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL data_stream cycle %0d: got %b required %b (act,dout,k,ws,pop)", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (data_cnt !== CW'(2)) begin
      fails++;
      $display("FAIL data_stream_cnt: got %0d required 2", data_cnt);
    end
  endtask

  task automatic test_random_words();
    int n;
    logic [7:0] w;
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      n = $urandom_range(1, 6);
      add_quiet(1);
      add_word(IDLE, 1'b1, 1'b1);
      for (int i = 0; i < n; i++) begin
        w = (rep == 0 && i == 0) ? 8'h07 : 8'($urandom_range(0, 255));
        fifo_q.push_back(w);
        add_word(w, 1'b0, (i < n - 1));
      end
      add_word(IDLE, 1'b1, 1'b0);
      add_word(IDLE, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1 enable = 1'b1;
      capture(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL random_words rep %0d cycle %0d: got %b required %b", rep, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (data_cnt !== CW'(n)) begin
        fails++;
        $display("FAIL random_words_cnt rep %0d: got %0d required %0d", rep, data_cnt, n);
      end
    end
  endtask

  task automatic test_enable_drop();
    // Part 1: enable drops after pop was issued for 8'h81.
    do_reset();
    fifo_q.push_back(8'h81);
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    add_quiet(1);
    add_word(IDLE, 1'b1, 1'b1);
    add_word(8'h81, 1'b0, 1'b0);
    add_quiet(4);
    capture(FRAME);                   // idle cycle + sync bits 0..FRAME-2
    @(posedge clk);
    #1 enable = 1'b0;                 // now in the last bit of the sync word
    capture(exp_q.size() - FRAME);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL enable_drop_popped cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (data_cnt !== CW'(1)) begin
      fails++;
      $display("FAIL enable_drop_cnt: got %0d required 1", data_cnt);
    end
    // Part 2: enable drops mid-sync with nothing popped.
    do_reset();
    enable = 1'b1;
    add_quiet(1);
    add_word(IDLE, 1'b1, 1'b0);
    add_quiet(3);
    capture(4);
    @(posedge clk);
    #1 enable = 1'b0;
    capture(exp_q.size() - 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL enable_drop_idle cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    fifo_q.push_back(8'h5A);
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    add_quiet(1);
    add_word(IDLE, 1'b1, 1'b1);
    capture(1 + FRAME + 4);           // ends on bit 3 of the data word
    for (int i = 0; i < 1 + FRAME; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL reset_mid_pre cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({pop, data_out, k_out, word_start, active, data_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_mid_async: got %b required all zero",
               {pop, data_out, k_out, word_start, active, data_cnt});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    obs_q.delete();
    add_quiet(1);
    add_word(IDLE, 1'b1, 1'b0);
    add_word(IDLE, 1'b1, 1'b0);
    capture(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL reset_mid_restart cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    logic [CW-1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    repeat (1 + FRAME) @(negedge clk);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);                 // first bit of data word i
      exp_cnt = CW'(i % 16);
      checks++;
      if (data_cnt !== exp_cnt || k_out !== 1'b0) begin
        fails++;
        $display("FAIL cnt_wrap word %0d: got cnt %0d k %b required cnt %0d k 0", i, data_cnt, k_out, exp_cnt);
      end
      repeat (FRAME - 1) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_fill();
    test_data_stream();
    test_random_words();
    test_enable_drop();
    test_reset_mid_word();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
